// File: rtl/rr_arb_pkg.sv
// Shared constants, state type and grant encoder for the 4-way round-robin arbiter.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // 4:2 encoder with the shared bit mapping idx[0] = g1|g3, idx[1] = g2|g3.
  // An all-zero input encodes to 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    return {oh[2] | oh[3], oh[1] | oh[3]};
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority selector: first set req bit at or after ptr, wrapping 3->0.
// Latency: purely combinational.
// Backpressure: none; found is low and onehot is zero when no request is set.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic             found
);

  // Walk the four positions starting at ptr; the first set request wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    onehot = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters; registered one-hot grant plus encoded index.
// Latency: req sampled at edge N drives gnt after edge N; release re-arbitrates on that same edge.
// Backpressure: a grant is held while req[cur] stays high; RR_TIMEOUT_EN adds a MAX_HOLD-cycle cap.
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cur_q, cur_d;

  logic [N_REQ-1:0] pick_onehot;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             timeout;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .onehot(pick_onehot),
    .found (pick_found)
  );

  assign pick_idx = onehot_to_idx(pick_onehot);

`ifdef RR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // The current grant has used its last allowed cycle.
  assign timeout = (hold_cnt_q == HOLD_LAST);

  // Hold counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  // Without the cap a grant only ends on release, so MAX_HOLD has no role.
  localparam int unused_max_hold = MAX_HOLD;

  assign timeout = 1'b0;
`endif

  // Next state: grant from IDLE, keep or re-arbitrate from BUSY.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
`ifdef RR_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          gnt_d   = pick_onehot;
          cur_d   = pick_idx;
          ptr_d   = pick_idx + IDX_W'(1);
`ifdef RR_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        if (req[cur_q] && !timeout) begin
`ifdef RR_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
`endif
        end else if (pick_found) begin
          // ptr already points past cur, so a lone holder is only re-granted
          // when nobody else is asking.
          gnt_d = pick_onehot;
          cur_d = pick_idx;
          ptr_d = pick_idx + IDX_W'(1);
`ifdef RR_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
`ifdef RR_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Arbiter state registers; reset clears the grant without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = onehot_to_idx(gnt_q);
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 4;
`ifdef RR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the resource (-1 = nobody), which index is
  // first in line next time, and how many cycles the owner has had so far.
  int owner = -1;
  int prio  = 0;
  int held  = 0;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    owner = -1;
    prio  = 0;
    held  = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r);
    bit rearb;
    int w;
    rearb = (owner < 0);
    if (!rearb) rearb = (r[owner] == 1'b0) || (TO_EN && held == MAX_HOLD);
    if (!rearb) begin
      held++;
    end else begin
      w = -1;
      for (int i = 0; i < 4; i++) begin
        if (w < 0 && r[(prio + i) % 4]) w = (prio + i) % 4;
      end
      if (w >= 0) begin
        owner = w;
        prio  = (w + 1) % 4;
        held  = 1;
      end else begin
        owner = -1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] e_gnt;
    logic [1:0] e_idx;
    e_gnt = (owner < 0) ? 4'b0000 : 4'(1 << owner);
    e_idx = (owner < 0) ? 2'd0 : 2'(owner);
    check({tag, "_gnt"}, 32'(gnt), 32'(e_gnt));
    check({tag, "_idx"}, 32'(gnt_idx), 32'(e_idx));
    check({tag, "_vld"}, 32'(gnt_valid), 32'(owner >= 0));
  endtask

  // Drive req for one cycle, let the model see the same sample, compare after the edge.
  task automatic cyc(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse issued between edges.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    check({tag, "_async_vld"}, 32'(gnt_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state before any clock edge.
    #2;
    model_reset();
    check_model("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset priority: requester 0 first, then rotation (with the cap).
    cyc(4'b1111, "prio_first");
    check("prio_first_lit", 32'(gnt), 32'h1);
    check("prio_first_idx_lit", 32'(gnt_idx), 32'h0);
    for (int i = 0; i < 20; i++) cyc(4'b1111, "prio_rot");

    // Release with back-to-back grant, then idle.
    do_reset("rst_a");
    cyc(4'b0101, "b2b_g0");
    check("b2b_g0_lit", 32'(gnt), 32'h1);
    cyc(4'b0101, "b2b_g0b");
    cyc(4'b0100, "b2b_g2");
    check("b2b_g2_lit", 32'(gnt), 32'h4);
    check("b2b_g2_idx_lit", 32'(gnt_idx), 32'h2);
    cyc(4'b0000, "b2b_idle");
    check("b2b_idle_lit", 32'(gnt_valid), 32'h0);

    // Lone requester: never drops, even across the cap.
    do_reset("rst_b");
    for (int i = 0; i < 10; i++) begin
      cyc(4'b1000, "lone");
      check("lone_lit", 32'(gnt), 32'h8);
    end

    // Fairness: after idx 1, the pointer wraps to 0 before reaching 1 again.
    do_reset("rst_c");
    cyc(4'b0010, "fair_g1");
    cyc(4'b0011, "fair_hold");
    cyc(4'b0001, "fair_g0");
    check("fair_g0_lit", 32'(gnt), 32'h1);

    // Reset mid-grant, then a fresh one-cycle grant.
    do_reset("rst_d");
    cyc(4'b0100, "mid_g2");
    cyc(4'b0100, "mid_g2b");
    check("mid_g2_lit", 32'(gnt), 32'h4);
    do_reset("mid_rst");
    check("mid_rst_lit", 32'(gnt), 32'h0);
    cyc(4'b0100, "mid_regrant");
    check("mid_regrant_lit", 32'(gnt), 32'h4);

    // Two steady requesters for 20 cycles.
    do_reset("rst_e");
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0011, "steady");
`ifndef RR_TIMEOUT_EN
      check("steady_lit", 32'(gnt), 32'h1);
`endif
    end

    // Random traffic with occasional asynchronous resets.
    do_reset("rst_f");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      if ($urandom_range(0, 3) == 0) cyc(4'($urandom), "rnd");
      else cyc(req ^ 4'(1 << $urandom_range(0, 3)) & {4{$urandom_range(0, 5) != 0}} | req & 4'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
